// File: rtl/parallel_adder.sv
// rtl/parallel_adder.sv - ripple-carry parallel adder with a one-stage registered result
//
// Purpose:
//   WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
//   The sum and carry-out are combinational. A one-cycle registered copy of the
//   result, with a signed-overflow flag and a valid strobe, is provided for
//   pipelined consumers.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears the registered outputs only)
//   a, b       WIDTH-bit operands, unsigned or two's complement
//   cin        carry into bit 0
//   in_valid   qualifies a/b/cin for capture on the next rising clk
//   sum, cout  combinational (a + b + cin), independent of clk and rst
//   sum_q      registered sum
//   cout_q     registered carry-out
//   ovf_q      registered signed overflow
//   out_valid  registered in_valid; marks sum_q/cout_q/ovf_q as fresh

module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module parallel_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             ovf_q,
   output logic             out_valid
);

   // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB cell.
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   logic             ovf;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign sum  = s;
   assign cout = c[WIDTH];

   // Signed overflow happens exactly when the carry into the MSB differs from
   // the carry out of it; this also covers WIDTH == 1 (c[0] is cin).
   assign ovf = c[WIDTH] ^ c[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q     <= '0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum_q  <= sum;
            cout_q <= cout;
            ovf_q  <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_parallel_adder.sv
// tb/tb_parallel_adder.sv - self-checking bench for parallel_adder

module tb_parallel_adder;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       in_valid;
   logic [7:0] sum;
   logic       cout;
   logic [7:0] sum_q;
   logic       cout_q;
   logic       ovf_q;
   logic       out_valid;

   int checks;
   int failures;

   parallel_adder #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .sum       (sum),
      .cout      (cout),
      .sum_q     (sum_q),
      .cout_q    (cout_q),
      .ovf_q     (ovf_q),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic       vcin;
      logic [7:0] esum;
      logic       ecout;
      logic       eovf;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[1] = '{8'h1B, 8'h25, 1'b0, 8'h40, 1'b0, 1'b0};
      vecs[2] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[3] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[4] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[8] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
   end

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
      #1;
      checks++;
      if ({sum_q, cout_q, ovf_q, out_valid} !== 11'd0) begin
         failures++;
         $display("FAIL reset_state got sum_q=%h cout_q=%b ovf_q=%b out_valid=%b want all 0",
                  sum_q, cout_q, ovf_q, out_valid);
      end
      // Clock edges with in_valid high must not capture while rst is high.
      in_valid = 1'b1; a = 8'h12; b = 8'h34;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({sum_q, cout_q, ovf_q, out_valid} !== 11'd0) begin
         failures++;
         $display("FAIL reset_held got sum_q=%h out_valid=%b want 0", sum_q, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
   endtask

   // Vectors are applied back to back with in_valid held high, so each result
   // must appear exactly one edge after it was presented.
   task automatic test_vectors();
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         a = vecs[i].va; b = vecs[i].vb; cin = vecs[i].vcin; in_valid = 1'b1;
         #1;
         checks++;
         if ({cout, sum} !== {vecs[i].ecout, vecs[i].esum}) begin
            failures++;
            $display("FAIL comb_vec%0d got cout=%b sum=%h want cout=%b sum=%h",
                     i, cout, sum, vecs[i].ecout, vecs[i].esum);
         end
         @(posedge clk);
         #1;
         checks++;
         if ({out_valid, cout_q, ovf_q, sum_q} !==
             {1'b1, vecs[i].ecout, vecs[i].eovf, vecs[i].esum}) begin
            failures++;
            $display("FAIL reg_vec%0d got out_valid=%b cout_q=%b ovf_q=%b sum_q=%h want 1 %b %b %h",
                     i, out_valid, cout_q, ovf_q, sum_q,
                     vecs[i].ecout, vecs[i].eovf, vecs[i].esum);
         end
      end
   endtask

   task automatic test_hold();
      // Last captured vector was FF + 01 + 0 -> sum 00, cout 1, ovf 0.
      a = 8'h7F; b = 8'h7F; cin = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, cout_q, ovf_q, sum_q} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL hold got out_valid=%b cout_q=%b ovf_q=%b sum_q=%h want 0 1 0 00",
                  out_valid, cout_q, ovf_q, sum_q);
      end
      checks++;
      if ({cout, sum} !== {1'b0, 8'hFF}) begin
         failures++;
         $display("FAIL hold_comb got cout=%b sum=%h want 0 ff", cout, sum);
      end
   endtask

   task automatic test_async_reset();
      a = 8'h80; b = 8'h80; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, cout_q, ovf_q, sum_q} !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
         failures++;
         $display("FAIL pre_async got out_valid=%b cout_q=%b ovf_q=%b sum_q=%h want 1 1 1 00",
                  out_valid, cout_q, ovf_q, sum_q);
      end
      a = 8'hC3; b = 8'h5A; cin = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({sum_q, cout_q, ovf_q, out_valid} !== 11'd0) begin
         failures++;
         $display("FAIL async_reset got sum_q=%h cout_q=%b ovf_q=%b out_valid=%b want all 0",
                  sum_q, cout_q, ovf_q, out_valid);
      end
      // C3 + 5A + 1 = 11E
      checks++;
      if ({cout, sum} !== {1'b1, 8'h1E}) begin
         failures++;
         $display("FAIL comb_in_reset got cout=%b sum=%h want 1 1e", cout, sum);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, cout_q, ovf_q, sum_q} !== {1'b1, 1'b1, 1'b0, 8'h1E}) begin
         failures++;
         $display("FAIL post_reset_capture got out_valid=%b cout_q=%b ovf_q=%b sum_q=%h want 1 1 0 1e",
                  out_valid, cout_q, ovf_q, sum_q);
      end
   endtask

   task automatic test_random_sweep();
      logic [8:0] exp;
      logic       eovf;
      int         bad;
      bad = 0;
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         in_valid = 1'b1;
         exp  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
         eovf = (a[7] == b[7]) && (exp[7] != a[7]);
         #1;
         checks++;
         if ({cout, sum} !== exp) begin
            failures++;
            if (bad < 10)
               $display("FAIL rand_comb a=%h b=%h cin=%b got %h want %h", a, b, cin, {cout, sum}, exp);
            bad++;
         end
         @(posedge clk);
         #1;
         checks++;
         if ({out_valid, ovf_q, cout_q, sum_q} !== {1'b1, eovf, exp}) begin
            failures++;
            if (bad < 10)
               $display("FAIL rand_reg a=%h b=%h cin=%b got v=%b ovf=%b %h want v=1 ovf=%b %h",
                        a, b, cin, out_valid, ovf_q, {cout_q, sum_q}, eovf, exp);
            bad++;
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_vectors();
      test_hold();
      test_async_reset();
      test_random_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parallel_adder.md
Name: parallel_adder

Overview:
- WIDTH-bit (default 8) ripple-carry parallel adder built as a chain of full-adder cells.
- Computes a + b + cin and produces the sum and carry-out combinationally.
- A one-stage registered copy of the result, with a signed-overflow flag and a valid strobe, is provided for pipelined consumers.
- Used as the basic arithmetic datapath element in the module library.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be 1 or more.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- in_valid  input  1  qualifies a/b/cin for capture into the output register.
- sum  output  WIDTH  combinational (a + b + cin) mod 2^WIDTH.
- cout  output  1  combinational carry-out of the MSB cell.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry-out.
- ovf_q  output  1  registered signed overflow.
- out_valid  output  1  registered in_valid; marks sum_q/cout_q/ovf_q as fresh.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Combinational path (no clock involvement):
  - Bit i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i].
  - c[0] = cin; cout = c[WIDTH]; sum = s.
  - Implemented as WIDTH instances of a full-adder cell chained by carry (generate loop), not a behavioural "+".
  - sum/cout settle within the same delta/propagation window after any input change; they are valid regardless of rst.
- {cout, sum} always equals the (WIDTH+1)-bit exact value of a + b + cin; no saturation.
- Signed overflow, combinational internal: ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
  - cin participates through sum; equivalently ovf = c[WIDTH] ^ c[WIDTH-1].
- Registered path:
  - On a rising clk with in_valid=1: sum_q<=sum, cout_q<=cout, ovf_q<=ovf, out_valid<=1.
  - On a rising clk with in_valid=0: sum_q/cout_q/ovf_q hold; out_valid<=0.
  - Latency is exactly 1 cycle from the in_valid edge to out_valid; throughput is 1 result per cycle; no backpressure.
- Reset:
  - rst=1 immediately (asynchronously) forces sum_q=0, cout_q=0, ovf_q=0, out_valid=0.
  - Registers stay cleared while rst is high. The first capture is on the first rising clk with rst low and in_valid high.
  - Reset asserted mid-stream discards the pending registered result; combinational outputs are unaffected.
- Boundaries:
  - All-ones + all-ones + 1 gives sum = all-ones, cout=1.
  - All-ones + 1 wraps sum to 0 with cout=1.
  - X/Z on inputs is not defined behaviour.

Test Plan:
- a=00000000, b=00000000, cin=0 -> sum=00000000, cout=0; one cycle after in_valid: sum_q=00000000, out_valid=1, ovf_q=0.
- a=00011011, b=00100101, cin=0 -> sum=01000000, cout=0, ovf=0; a=10101010, b=01010101, cin=0 -> sum=11111111, cout=0.
- a=11110000, b=00001111, cin=1 -> sum=00000000, cout=1, ovf=0; a=11111111, b=00000001, cin=1 -> sum=00000001, cout=1.
- a=10000000, b=10000000, cin=0 -> sum=00000000, cout=1, ovf_q=1 after one clk.
- a=11111111, b=11111111, cin=1 -> sum=11111111, cout=1, ovf=0.
- Assert rst between clock edges while out_valid=1 -> sum_q, cout_q, ovf_q, out_valid drop to 0 immediately. Drive in_valid=0 for one cycle -> out_valid=0, registered outputs held. Random 1000-vector sweep -> {cout, sum} equals a+b+cin every time.
